// File: rtl/pixel_write_arbiter.sv
// Round-robin, packet-locked arbiter sharing the single VGA pixel-write port
// between the drawing engines; transparent sprite pixels are accepted but not written.
module pixel_write_arbiter #(
    parameter int             N                = 4,
    parameter int             XW               = 9,
    parameter int             YW               = 8,
    parameter int             CW               = 12,
    parameter logic [N-1:0]   TRANSPARENT_MASK = 4'b0011
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N-1:0]      req_valid,
    input  logic [N-1:0]      req_last,
    input  logic [N*XW-1:0]   req_x,
    input  logic [N*YW-1:0]   req_y,
    input  logic [N*CW-1:0]   req_color,
    output logic [N-1:0]      req_ready,
    output logic [N-1:0]      grant,
    output logic              busy,
    output logic [XW-1:0]     X_out,
    output logic [YW-1:0]     Y_out,
    output logic [CW-1:0]     Color_out,
    output logic              writeEn
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_grant;
    logic [LW-1:0]   r_last_grant;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [CW-1:0]   r_color;
    logic            r_we;

    logic [LW-1:0]   w_pick_idx;
    logic            w_found;
    logic [LW-1:0]   w_gidx;
    logic            w_xfer;
    logic [XW-1:0]   w_gx;
    logic [YW-1:0]   w_gy;
    logic [CW-1:0]   w_gc;
    logic            w_transp;

    // Scan starts one past the previous owner so every engine gets a turn.
    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_found    = 1'b0;
        w_pick_idx = r_last_grant;
        for (int k = 1; k <= N; k++) begin
            v_idx = (int'(r_last_grant) + k) % N;
            if (!w_found && req_valid[v_idx]) begin
                w_found    = 1'b1;
                w_pick_idx = LW'(v_idx);
            end
        end
    end

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) w_gidx = LW'(i);
        end
    end

    assign w_gx     = req_x[w_gidx*XW +: XW];
    assign w_gy     = req_y[w_gidx*YW +: YW];
    assign w_gc     = req_color[w_gidx*CW +: CW];
    assign w_xfer   = (r_state == S_LOCKED) && |(req_valid & r_grant);
    assign w_transp = TRANSPARENT_MASK[w_gidx] && (w_gc == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= LW'(N - 1);
            r_x          <= '0;
            r_y          <= '0;
            r_color      <= '0;
            r_we         <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
                        r_state <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (w_xfer) begin
                        r_x     <= w_gx;
                        r_y     <= w_gy;
                        r_color <= w_gc;
                        r_we    <= !w_transp;
                        // Packet end releases the port; IDLE gives the one dead cycle.
                        if (req_last[w_gidx]) begin
                            r_last_grant <= w_gidx;
                            r_grant      <= '0;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Handshake: engine i's pixel moves on a rising edge where req_valid[i] & req_ready[i].
    assign req_ready = r_grant;
    assign grant     = r_grant;
    assign busy      = (r_state == S_LOCKED);
    assign X_out     = r_x;
    assign Y_out     = r_y;
    assign Color_out = r_color;
    assign writeEn   = r_we;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: per-engine pixel queues drive the
// requests, a round-robin packet model fills the expected queue, a monitor checks.
module tb_pixel_write_arbiter;

    localparam int N  = 4;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 12;
    localparam logic [3:0] MASK = 4'b0011;

    logic              clk;
    logic              resetn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*XW-1:0]   req_x;
    logic [N*YW-1:0]   req_y;
    logic [N*CW-1:0]   req_color;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      grant;
    logic              busy;
    logic [XW-1:0]     X_out;
    logic [YW-1:0]     Y_out;
    logic [CW-1:0]     Color_out;
    logic              writeEn;

    pixel_write_arbiter #(
        .N(N), .XW(XW), .YW(YW), .CW(CW), .TRANSPARENT_MASK(MASK)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .req_ready(req_ready), .grant(grant), .busy(busy),
        .X_out(X_out), .Y_out(Y_out), .Color_out(Color_out), .writeEn(writeEn)
    );

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        logic          last;
    } pix_t;

    // Expected entry: {source[1:0], writeEn, X[8:0], Y[7:0], Color[11:0]}
    logic [31:0] exp_q[$];
    pix_t        pix_q[N][$];
    pix_t        m_q[N][$];
    int          m_last;
    int          gap[N];
    int          fixed_gap;
    int          checks;
    int          failures;
    logic        pend;
    logic        pend_last;
    logic [1:0]  pend_idx;
    logic        prev_idle_req;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_X"}, 32'(X_out), 32'd0);
        chk({tag, "_Y"}, 32'(Y_out), 32'd0);
        chk({tag, "_C"}, 32'(Color_out), 32'd0);
        chk({tag, "_we"}, 32'(writeEn), 32'd0);
    endtask

    // ---------------- stimulus and model ----------------
    task automatic add_pix(input int r, input int x, input int y, input int c, input bit last);
        pix_t p;
        p.x = XW'(x); p.y = YW'(y); p.c = CW'(c); p.last = last;
        pix_q[r].push_back(p);
        m_q[r].push_back(p);
    endtask

    task automatic add_rand_pkt(input int r, input int len);
        int c;
        for (int k = 0; k < len; k++) begin
            c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4095));
            add_pix(r, int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), c, k == len - 1);
        end
    endtask

    // Whole packets, served round-robin from the engine after the last owner.
    task automatic model_phase();
        pix_t p;
        int   r;
        bit   any;
        forever begin
            any = 0;
            r   = 0;
            for (int k = 1; k <= N; k++) begin
                if (!any && m_q[(m_last + k) % N].size() != 0) begin
                    any = 1;
                    r   = (m_last + k) % N;
                end
            end
            if (!any) break;
            do begin
                p = m_q[r].pop_front();
                exp_q.push_back({2'(r), !(MASK[r] && p.c == 0), p.x, p.y, p.c});
            end while (!p.last);
            m_last = r;
        end
    endtask

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(posedge clk);
            done = (exp_q.size() == 0) && !pend;
            for (int i = 0; i < N; i++) if (pix_q[i].size() != 0) done = 0;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pending expected 0", tag, exp_q.size());
            finish_now();
        end
        repeat (2) @(posedge clk);
    endtask

    // Load packets at posedge+3; the driver puts them on the bus at the next posedge+1.
    task automatic sync_load();
        @(posedge clk);
        #3;
    endtask

    // Driver: pops an engine's pixel after its handshake, inserts gaps only mid-packet.
    initial begin
        logic [N-1:0] hs;
        pix_t p;
        req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_color = '0;
        for (int i = 0; i < N; i++) gap[i] = 0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && pix_q[i].size() != 0) begin
                    p = pix_q[i].pop_front();
                    if (!p.last) gap[i] = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 3));
                end
                if (pix_q[i].size() == 0) begin
                    req_valid[i] = 1'b0;
                end else if (gap[i] > 0) begin
                    req_valid[i] = 1'b0;
                    gap[i]--;
                end else begin
                    p = pix_q[i][0];
                    req_valid[i]              = 1'b1;
                    req_last[i]               = p.last;
                    req_x[i*XW +: XW]         = p.x;
                    req_y[i*YW +: YW]         = p.y;
                    req_color[i*CW +: CW]     = p.c;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [N-1:0] hs;
        logic [31:0]  e;
        pend = 0; pend_last = 0; pend_idx = '0; prev_idle_req = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pend = 0;
                prev_idle_req = 0;
                continue;
            end
            if (pend) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 32'(pend_idx), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("source", 32'(pend_idx), 32'(e[31:30]));
                    chk("writeEn", 32'(writeEn), 32'(e[29]));
                    chk("X_out", 32'(X_out), 32'(e[28:20]));
                    chk("Y_out", 32'(Y_out), 32'(e[19:12]));
                    chk("Color_out", 32'(Color_out), 32'(e[11:0]));
                end
                if (pend_last) chk("dead_cycle_grant", 32'(grant), 32'd0);
            end else begin
                chk("idle_writeEn", 32'(writeEn), 32'd0);
            end
            chk("ready_is_grant", 32'(req_ready), 32'(grant));
            chk("busy_vs_grant", 32'(busy), 32'(grant != 0));
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (prev_idle_req) chk("grant_latency", 32'(grant != 0), 32'd1);
            prev_idle_req = (grant == 0) && (req_valid != 0);
            hs = req_valid & req_ready;
            chk("handshake_onehot0", 32'($onehot0(hs)), 32'd1);
            pend = |hs;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    pend_idx  = 2'(i);
                    pend_last = req_last[i];
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        bit any;
        int r;
        checks = 0; failures = 0; m_last = N - 1; fixed_gap = 0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk_reset_outputs("rst");
        resetn = 1'b1;

        // Background 3-pixel packet
        sync_load();
        for (int k = 0; k < 3; k++) add_pix(2, k, 5, 12'hF00, k == 2);
        model_phase();
        drain("bg3");

        // All four single-pixel, then gold again
        sync_load();
        for (int i = 0; i < N; i++) add_pix(i, 100 + i, 50 + i, 12'h0A0 + i, 1);
        add_pix(0, 200, 60, 12'h123, 1);
        model_phase();
        drain("rr4");

        // Transparency: gold masked, background not
        sync_load();
        add_pix(0, 10, 20, 12'h000, 0);
        add_pix(0, 11, 20, 12'hFF0, 1);
        model_phase();
        drain("transp_gold");
        sync_load();
        add_pix(2, 30, 40, 12'h000, 1);
        model_phase();
        drain("transp_bg");

        // Hook with 5-cycle valid gaps while stone waits
        fixed_gap = 5;
        sync_load();
        for (int k = 0; k < 3; k++) add_pix(3, 300 + k, 7, 12'h00F, k == 2);
        add_pix(1, 77, 88, 12'h555, 1);
        model_phase();
        drain("hook_gap");

        // Back-to-back packets from background
        fixed_gap = 0;
        sync_load();
        for (int k = 0; k < 4; k++) add_pix(2, 400 + k, 9, 12'h321, k == 1 || k == 3);
        model_phase();
        drain("b2b");

        // Randomized phases
        fixed_gap = -1;
        for (int ph = 0; ph < 25; ph++) begin
            sync_load();
            any = 0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    any = 1;
                    for (int n = 0; n < int'($urandom_range(1, 2)); n++)
                        add_rand_pkt(i, int'($urandom_range(1, 4)));
                end
            end
            if (!any) add_rand_pkt(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            model_phase();
            drain("rand");
        end

        // Reset mid-packet while stone owns the port
        fixed_gap = 0;
        sync_load();
        add_rand_pkt(1, 10);
        model_phase();
        r = 0;
        while (grant != 4'b0010 && r < 50) begin
            @(negedge clk);
            r++;
        end
        chk("stone_locked", 32'(grant), 32'h2);
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        for (int i = 0; i < N; i++) begin
            pix_q[i].delete();
            m_q[i].delete();
            gap[i] = 0;
        end
        exp_q.delete();
        req_valid = '0;
        m_last = N - 1;
        repeat (2) @(posedge clk);
        #3;
        add_rand_pkt(1, 2);
        add_rand_pkt(0, 2);
        model_phase();
        resetn = 1'b1;
        drain("post_rst");

        finish_now();
    end

endmodule
